cmd_host: RTL and testbench
===========================

# cmd_host

Host-side command initiator for the UART register-access protocol; the counterpart of the device-side command interpreter. It accepts register read/write requests over a valid/ready port and serialises them into protocol bytes for the UART transmitter. The command byte is `{wr, addr[6:0]}`; a write is followed by one data byte. For reads, it collects the single response byte from the UART receiver and guards that wait with a timeout. Sits between a local controller (test sequencer/CPU shim) and the UART TX/RX pair.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: cycles spent in WAIT before a read is abandoned; legal range ≥ 2.

Ports:
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: block can accept a request.
- `req_wr_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in 7: register address.
- `req_wdata_i` in 8: write data; ignored for reads.
- `tx_valid_o` out 1: byte offered to the UART TX.
- `tx_data_o` out 8: byte offered.
- `tx_ready_i` in 1: UART TX accepts the byte this cycle.
- `rx_received_i` in 1: one-cycle strobe, byte received from the UART RX.
- `rx_data_i` in 8: received byte.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_rdata_o` out 8: read data, or 8'hFF on timeout.
- `rsp_timeout_o` out 1: qualifies `rsp_valid_o`; the read timed out.
- `busy_o` out 1: high whenever state ≠ IDLE.

## Operation
- **States:** IDLE, CMD, DATA, WAIT.
- **IDLE:**
  - `req_ready_o = 1`, combinational on state.
  - On `req_valid_i & req_ready_o`, latch `wr`, `addr` and `wdata`, then go to CMD.
- **CMD:**
  - `tx_valid_o = 1`, `tx_data_o = {wr, addr}`.
  - On `tx_ready_i`: go to DATA if `wr`, else go to WAIT and clear the timeout counter.
- **DATA:**
  - `tx_valid_o = 1`, `tx_data_o = wdata`.
  - On `tx_ready_i`: return to IDLE and register `rsp_valid_o = 1`, `rsp_timeout_o = 0`. `rsp_rdata_o` is unchanged.
- **WAIT:**
  - The counter increments each cycle.
  - On `rx_received_i`: `rsp_rdata_o <= rx_data_i`, `rsp_timeout_o <= 0`, `rsp_valid_o <= 1`, return to IDLE.
  - Else, when counter == `TIMEOUT_CYCLES-1`: `rsp_rdata_o <= 8'hFF`, `rsp_timeout_o <= 1`, `rsp_valid_o <= 1`, return to IDLE.
- **TX handshake:** a byte transfers only when `tx_valid_o & tx_ready_i`. `tx_data_o` is held stable while `tx_valid_o` waits. `tx_valid_o` never deasserts before acceptance.
- **Boundary conditions:**
  - `rx_received_i` outside WAIT is ignored; stray bytes are dropped and no state changes.
  - `rx_received_i` in the same cycle the counter reaches terminal count: the received byte wins and there is no timeout.
  - Request fields are sampled only at acceptance; later changes on `req_*` have no effect.
  - A new request may be accepted in the same cycle `rsp_valid_o` is high, since the state is already IDLE.
  - Reset mid-transaction aborts immediately: state IDLE, no response pulse, partial TX sequence abandoned.
- **Reset values:** state IDLE; `req_ready_o = 1`, `tx_valid_o = 0`, `tx_data_o = 0`, `rsp_valid_o = 0`, `rsp_rdata_o = 0`, `rsp_timeout_o = 0`, `busy_o = 0`, counter 0.

## Timing
- Request accepted at edge 0 → `tx_valid_o` high from cycle 1.
- Write with `tx_ready_i` tied high: command byte in cycle 1, data byte in cycle 2, `rsp_valid_o` in cycle 3. Each TX stall cycle adds one cycle.
- Read: command byte accepted in cycle n puts the block in WAIT at cycle n+1. `rx_received_i` in cycle k → `rsp_valid_o` in cycle k+1.
- Read with no response: WAIT entered at cycle w → `rsp_valid_o` with timeout in cycle w+`TIMEOUT_CYCLES`.
- `rsp_valid_o` is exactly one cycle wide. `rsp_rdata_o` and `rsp_timeout_o` hold until the next response.
- Counter width `$clog2(TIMEOUT_CYCLES)`; it never wraps because it is cleared on WAIT entry.

## Structure
- **Shared package `cmd_pkg`:**
  - State enum `cmd_host_state_e`.
  - `CMD_WR_BIT = 7`, `ADDR_W = 7`, `DATA_W = 8`, `RSP_TIMEOUT_DATA = 8'hFF`.
  - The package is shared with the device-side interpreter.
- **Sub-module `cmd_timeout_cnt`:** clear/enable/terminal-count counter, parameterised by `TIMEOUT_CYCLES`.

## Test plan
- **Write, TX always ready:** req wr=1, addr=7'h15, wdata=8'hA5 → TX bytes 8'h95 (cycle 1), 8'hA5 (cycle 2); `rsp_valid_o` in cycle 3 with `rsp_timeout_o = 0`.
- **Write with TX back-pressure:** `tx_ready_i` low for 5 cycles → `tx_data_o` held at 8'h95 throughout; sequence completes 5 cycles later.
- **Read:** addr=7'h03 → TX 8'h03; `rx_received_i` with 8'h5C three cycles later → `rsp_rdata_o = 8'h5C`, `rsp_timeout_o = 0`, `busy_o` falls.
- **Read timeout** (`TIMEOUT_CYCLES = 16`): no RX → `rsp_valid_o` 16 cycles after WAIT entry with `rsp_rdata_o = 8'hFF`, `rsp_timeout_o = 1`. Repeat with RX in the terminal cycle → data returned, no timeout.
- **Stray RX and back-to-back requests:** RX strobe in IDLE/CMD is ignored; a second request presented during the `rsp_valid_o` cycle is accepted at that edge.
- **Reset mid-read** (in WAIT) → all outputs at reset values, no `rsp_valid_o`; the next request runs normally.

Source files
------------

// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared definitions for the UART register-access command protocol
package cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_WAIT = 2'd3
  } cmd_host_state_e;

  localparam int CMD_WR_BIT = 7;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  localparam logic [DATA_W-1:0] RSP_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// rtl/cmd_timeout_cnt.sv - clearable cycle counter flagging the last cycle of a timeout window
module cmd_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/cmd_host.sv
// rtl/cmd_host.sv - host-side initiator serialising register requests to UART bytes
module cmd_host
  import cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wr_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                tx_valid_o,
  output logic [DATA_W-1:0]   tx_data_o,
  input  logic                tx_ready_i,
  input  logic                rx_received_i,
  input  logic [DATA_W-1:0]   rx_data_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_timeout_o,
  output logic                busy_o
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CMD  = ST_CMD;
  localparam logic [1:0] S_DATA = ST_DATA;
  localparam logic [1:0] S_WAIT = ST_WAIT;

  logic [1:0]        state_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cmd_byte;
  logic              cnt_clr;
  logic              cnt_tc;

  always_comb begin
    cmd_byte = '0;
    cmd_byte[CMD_WR_BIT]   = wr_q;
    cmd_byte[ADDR_W-1:0]   = addr_q;
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign tx_valid_o  = (state_q == S_CMD) || (state_q == S_DATA);

  always_comb begin
    tx_data_o = '0;
    if (state_q == S_CMD) begin
      tx_data_o = cmd_byte;
    end else if (state_q == S_DATA) begin
      tx_data_o = wdata_q;
    end
  end

  // Counter restarts exactly when the read command byte leaves, so WAIT always begins at zero.
  assign cnt_clr = (state_q == S_CMD) && tx_ready_i && !wr_q;

  cmd_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (cnt_clr),
    .en_i    (state_q == S_WAIT),
    .tc_o    (cnt_tc)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            wr_q    <= req_wr_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            state_q <= S_CMD;
          end
        end
        S_CMD: begin
          if (tx_ready_i) begin
            state_q <= wr_q ? S_DATA : S_WAIT;
          end
        end
        S_DATA: begin
          if (tx_ready_i) begin
            rsp_valid_o   <= 1'b1;
            rsp_timeout_o <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          // A byte arriving on the terminal cycle takes priority over the timeout.
          if (rx_received_i) begin
            rsp_rdata_o   <= rx_data_i;
            rsp_timeout_o <= 1'b0;
            rsp_valid_o   <= 1'b1;
            state_q       <= S_IDLE;
          end else if (cnt_tc) begin
            rsp_rdata_o   <= RSP_TIMEOUT_DATA;
            rsp_timeout_o <= 1'b1;
            rsp_valid_o   <= 1'b1;
            state_q       <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_host.sv
// tb/tb_cmd_host.sv - self-checking scoreboard bench for cmd_host
module tb_cmd_host;

  typedef struct {
    logic       to;
    logic [7:0] d;
  } rsp_t;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_received;
  logic [7:0] rx_data;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       busy;

  logic [7:0] tx_q[$];
  rsp_t       rsp_q[$];
  logic [7:0] model_rdata;
  logic [7:0] exp_b;
  rsp_t       exp_r;
  int         checks;
  int         failures;

  cmd_host #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_wr_i      (req_wr),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .tx_valid_o    (tx_valid),
    .tx_data_o     (tx_data),
    .tx_ready_i    (tx_ready),
    .rx_received_i (rx_received),
    .rx_data_i     (rx_data),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_timeout_o (rsp_timeout),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [6:0] addr, input logic [7:0] wdata);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    tx_q.push_back({wr, addr});
    if (wr) begin
      tx_q.push_back(wdata);
      rsp_q.push_back('{1'b0, model_rdata});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    tx_ready = 1'b0; rx_received = 1'b0; rx_data = '0;
    model_rdata = 8'h00;
    repeat (2) tick();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=00", rsp_rdata); end
    checks++; if (rsp_timeout !== 1'b0) begin failures++; $display("FAIL reset_rsp_timeout got=%b exp=0", rsp_timeout); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    tx_ready = 1'b1;
    issue(1'b1, 7'h15, 8'hA5);
    tick();
    req_valid = 1'b0; req_wr = 1'b0; req_addr = 7'h7F; req_wdata = 8'h00;
    for (int i = 0; i < 2; i++) begin
      exp_b = tx_q.pop_front();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
        failures++; $display("FAIL write_tx%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b);
      end
      tick();
    end
    exp_r = rsp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== exp_r.to || rsp_rdata !== exp_r.d) begin
      failures++; $display("FAIL write_rsp got=%b/%b/%h exp=1/%b/%h", rsp_valid, rsp_timeout, rsp_rdata, exp_r.to, exp_r.d);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL write_after got=%b/%b exp=0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int n;
    tx_ready = 1'b0;
    issue(1'b1, 7'h15, 8'hA5);
    tick();
    req_valid = 1'b0; req_addr = 7'h2A; req_wdata = 8'h3C;
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h95) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/95", i, tx_valid, tx_data);
      end
      tick();
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_b = tx_q.pop_front();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
        failures++; $display("FAIL bp_tx%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b);
      end
      tick();
    end
    n = 8;
    exp_r = rsp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== exp_r.to || rsp_rdata !== exp_r.d) begin
      failures++; $display("FAIL bp_rsp cyc=%0d got=%b/%b/%h exp=1/%b/%h", n, rsp_valid, rsp_timeout, rsp_rdata, exp_r.to, exp_r.d);
    end
    tick();
  endtask

  task automatic test_read();
    tx_ready = 1'b1;
    issue(1'b0, 7'h03, 8'hEE);
    tick();
    req_valid = 1'b0;
    exp_b = tx_q.pop_front();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
      failures++; $display("FAIL read_cmd got=%b/%h exp=1/%h", tx_valid, tx_data, exp_b);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL read_wait got=%b/%b exp=0/1", tx_valid, busy);
    end
    tick(); tick();
    rx_received = 1'b1; rx_data = 8'h5C;
    model_rdata = 8'h5C; rsp_q.push_back('{1'b0, 8'h5C});
    tick();
    rx_received = 1'b0; rx_data = 8'h00;
    exp_r = rsp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== exp_r.to || rsp_rdata !== exp_r.d || busy !== 1'b0) begin
      failures++; $display("FAIL read_rsp got=%b/%b/%h busy=%b exp=1/%b/%h busy=0", rsp_valid, rsp_timeout, rsp_rdata, busy, exp_r.to, exp_r.d);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h5C) begin
      failures++; $display("FAIL read_hold got=%b/%h exp=0/5c", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_timeout();
    int n;
    tx_ready = 1'b1;
    issue(1'b0, 7'h21, 8'h00);
    tick();
    req_valid = 1'b0;
    exp_b = tx_q.pop_front();
    checks++;
    if (tx_data !== exp_b) begin failures++; $display("FAIL to_cmd got=%h exp=%h", tx_data, exp_b); end
    tick();
    model_rdata = 8'hFF; rsp_q.push_back('{1'b1, 8'hFF});
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != 16) begin failures++; $display("FAIL to_latency got=%0d exp=16", n); end
    exp_r = rsp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== exp_r.to || rsp_rdata !== exp_r.d) begin
      failures++; $display("FAIL to_rsp got=%b/%b/%h exp=1/%b/%h", rsp_valid, rsp_timeout, rsp_rdata, exp_r.to, exp_r.d);
    end
    tick();
    issue(1'b0, 7'h22, 8'h00);
    tick();
    req_valid = 1'b0;
    exp_b = tx_q.pop_front();
    checks++;
    if (tx_data !== exp_b) begin failures++; $display("FAIL tc_cmd got=%h exp=%h", tx_data, exp_b); end
    tick();
    repeat (15) tick();
    rx_received = 1'b1; rx_data = 8'h3C;
    model_rdata = 8'h3C; rsp_q.push_back('{1'b0, 8'h3C});
    tick();
    rx_received = 1'b0;
    exp_r = rsp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== exp_r.to || rsp_rdata !== exp_r.d) begin
      failures++; $display("FAIL tc_rsp got=%b/%b/%h exp=1/%b/%h", rsp_valid, rsp_timeout, rsp_rdata, exp_r.to, exp_r.d);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b0;
    rx_received = 1'b1; rx_data = 8'h77;
    tick();
    rx_received = 1'b0;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== model_rdata) begin
      failures++; $display("FAIL stray_idle got=%b/%b/%h exp=0/0/%h", busy, rsp_valid, rsp_rdata, model_rdata);
    end
    issue(1'b0, 7'h11, 8'h00);
    tick();
    req_valid = 1'b0;
    rx_received = 1'b1; rx_data = 8'h66;
    tick(); tick();
    rx_received = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL stray_cmd got=%b/%h/%b exp=1/11/0", tx_valid, tx_data, rsp_valid);
    end
    tx_ready = 1'b1;
    exp_b = tx_q.pop_front();
    tick();
    rx_received = 1'b1; rx_data = 8'h11;
    model_rdata = 8'h11; rsp_q.push_back('{1'b0, 8'h11});
    tick();
    rx_received = 1'b0;
    exp_r = rsp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_r.d || rsp_timeout !== exp_r.to || req_ready !== 1'b1) begin
      failures++; $display("FAIL b2b_rsp got=%b/%h/%b rdy=%b exp=1/%h/%b rdy=1", rsp_valid, rsp_rdata, rsp_timeout, req_ready, exp_r.d, exp_r.to);
    end
    issue(1'b1, 7'h0A, 8'h44);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_b = tx_q.pop_front();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
        failures++; $display("FAIL b2b_tx%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b);
      end
      tick();
    end
    exp_r = rsp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_r.d || rsp_timeout !== exp_r.to) begin
      failures++; $display("FAIL b2b_wr_rsp got=%b/%h/%b exp=1/%h/%b", rsp_valid, rsp_rdata, rsp_timeout, exp_r.d, exp_r.to);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    tx_ready = 1'b1;
    issue(1'b0, 7'h05, 8'h00);
    tick();
    req_valid = 1'b0;
    void'(tx_q.pop_front());
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    model_rdata = 8'h00;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_data !== 8'h00 || rsp_valid !== 1'b0 ||
        rsp_rdata !== 8'h00 || rsp_timeout !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_outputs busy=%b txv=%b txd=%h rv=%b rd=%h to=%b rdy=%b exp=0 0 00 0 00 0 1",
                           busy, tx_valid, tx_data, rsp_valid, rsp_rdata, rsp_timeout, req_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++; $display("FAIL midrst_quiet cyc=%0d got=%b/%b exp=0/0", i, rsp_valid, busy);
      end
    end
    issue(1'b1, 7'h01, 8'h02);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_b = tx_q.pop_front();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
        failures++; $display("FAIL midrst_tx%0d got=%b/%h exp=1/%h", i, tx_valid, tx_data, exp_b);
      end
      tick();
    end
    exp_r = rsp_q.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_r.d || rsp_timeout !== exp_r.to) begin
      failures++; $display("FAIL midrst_rsp got=%b/%h/%b exp=1/%h/%b", rsp_valid, rsp_rdata, rsp_timeout, exp_r.d, exp_r.to);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write();
    test_backpressure();
    test_read();
    test_timeout();
    test_back_to_back();
    test_reset_mid_read();
    checks++;
    if (tx_q.size() != 0 || rsp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain tx_left=%0d rsp_left=%0d exp=0/0", tx_q.size(), rsp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
